// File: rtl/agc_update_sequencer.sv
// AGC threshold update sequencer: snapshots a Vpp/TLV measurement, drives the shared
// pipelined divider, then saturates and publishes the next threshold level.
module agc_update_sequencer #(
  parameter int OFFSET   = 1397,
  parameter int GAIN     = 1550,
  parameter int DIV_LAT  = 8,
  parameter int VPP_MIN  = 16,
  parameter int TLV_INIT = 2048
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        found,
  input  logic [11:0] vpp,
  input  logic [11:0] tlv,
  output logic [21:0] div_numer,
  output logic [11:0] div_denom,
  output logic        div_clken,
  input  logic [21:0] div_quotient,
  output logic [11:0] tlvnxt,
  output logic        tlv_valid,
  output logic        busy,
  output logic        err_vpp,
  output logic        overrun
);

  // state   | meaning
  // IDLE    | waiting for a found rising edge
  // RUN     | divider enabled, counting DIV_LAT+1 cycles
  // CAPTURE | quotient settled; register saturated level
  // DONE    | start queued request if one is pending
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [4:0]  CNT_LAST = 5'(DIV_LAT);
  localparam logic [11:0] VPP_LIM  = 12'(VPP_MIN);
  localparam logic [11:0] OFS12    = 12'(OFFSET);
  localparam logic [22:0] OFS23    = 23'(OFFSET);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        found_dly_q, found_dly_d;
  logic [21:0] op_numer_q, op_numer_d;
  logic [11:0] op_denom_q, op_denom_d;
  logic        pending_q, pending_d;
  logic [11:0] pend_vpp_q, pend_vpp_d;
  logic [11:0] pend_tlv_q, pend_tlv_d;
  logic [11:0] tlvnxt_q, tlvnxt_d;
  logic        tlv_valid_q, tlv_valid_d;
  logic        err_vpp_q, err_vpp_d;
  logic        overrun_q, overrun_d;

  logic        edge_e;
  logic        ld_req;
  logic [11:0] ld_vpp, ld_tlv;
  logic [22:0] sum;
  logic [11:0] sat_level;

  function automatic logic [21:0] scale(input logic [11:0] t);
    logic [11:0] diff;
    diff = (t > OFS12) ? t - OFS12 : 12'd0;
    return 22'(GAIN) * {10'd0, diff};
  endfunction

  assign edge_e    = found & ~found_dly_q;
  assign sum       = {1'b0, div_quotient} + OFS23;
  assign sat_level = (sum > 23'd4095) ? 12'hFFF : sum[11:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    found_dly_d = found;
    op_numer_d  = op_numer_q;
    op_denom_d  = op_denom_q;
    pending_d   = pending_q;
    pend_vpp_d  = pend_vpp_q;
    pend_tlv_d  = pend_tlv_q;
    tlvnxt_d    = tlvnxt_q;
    tlv_valid_d = 1'b0;
    err_vpp_d   = 1'b0;
    overrun_d   = 1'b0;
    ld_req      = 1'b0;
    ld_vpp      = vpp;
    ld_tlv      = tlv;

    case (state_q)
      ST_IDLE: begin
        if (edge_e) ld_req = 1'b1;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tlvnxt_d    = sat_level;
        tlv_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: begin
        if (pending_q) begin
          ld_req    = 1'b1;
          ld_vpp    = pend_vpp_q;
          ld_tlv    = pend_tlv_q;
          pending_d = 1'b0;
        end else if (edge_e) begin
          ld_req = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // A trigger in DONE with nothing queued is consumed directly above, not queued.
    if (edge_e && state_q != ST_IDLE && !(state_q == ST_DONE && !pending_q)) begin
      pend_vpp_d = vpp;
      pend_tlv_d = tlv;
      pending_d  = 1'b1;
      overrun_d  = pending_q && (state_q != ST_DONE);
    end

    if (ld_req) begin
      if (ld_vpp < VPP_LIM) begin
        err_vpp_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        op_numer_d = scale(ld_tlv);
        op_denom_d = ld_vpp;
        cnt_d      = 5'd0;
        state_d    = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      found_dly_q <= 1'b0;
      op_numer_q  <= 22'd0;
      op_denom_q  <= 12'd0;
      pending_q   <= 1'b0;
      pend_vpp_q  <= 12'd0;
      pend_tlv_q  <= 12'd0;
      tlvnxt_q    <= 12'(TLV_INIT);
      tlv_valid_q <= 1'b0;
      err_vpp_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      found_dly_q <= found_dly_d;
      op_numer_q  <= op_numer_d;
      op_denom_q  <= op_denom_d;
      pending_q   <= pending_d;
      pend_vpp_q  <= pend_vpp_d;
      pend_tlv_q  <= pend_tlv_d;
      tlvnxt_q    <= tlvnxt_d;
      tlv_valid_q <= tlv_valid_d;
      err_vpp_q   <= err_vpp_d;
      overrun_q   <= overrun_d;
    end
  end

  assign div_numer = op_numer_q;
  assign div_denom = op_denom_q;
  assign div_clken = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign tlvnxt    = tlvnxt_q;
  assign tlv_valid = tlv_valid_q;
  assign err_vpp   = err_vpp_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_agc_update_sequencer.sv
// Bench for agc_update_sequencer: vector table, hand-written corner sequences and
// randomized requests checked against an arithmetic reference of the level update.
module tb_agc_update_sequencer;
  localparam int OFFSET   = 1397;
  localparam int GAIN     = 1550;
  localparam int DIV_LAT  = 8;
  localparam int VPP_MIN  = 16;
  localparam int TLV_INIT = 2048;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        found;
  logic [11:0] vpp_i, tlv_i;
  logic [21:0] div_numer;
  logic [11:0] div_denom;
  logic        div_clken;
  logic [21:0] div_quotient;
  logic [11:0] tlvnxt;
  logic        tlv_valid, busy, err_vpp, overrun;

  agc_update_sequencer #(
    .OFFSET(OFFSET), .GAIN(GAIN), .DIV_LAT(DIV_LAT), .VPP_MIN(VPP_MIN), .TLV_INIT(TLV_INIT)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .found(found), .vpp(vpp_i), .tlv(tlv_i),
    .div_numer(div_numer), .div_denom(div_denom), .div_clken(div_clken),
    .div_quotient(div_quotient), .tlvnxt(tlvnxt), .tlv_valid(tlv_valid),
    .busy(busy), .err_vpp(err_vpp), .overrun(overrun)
  );

  always #10 clk_50M = ~clk_50M;

  // Behavioural pipelined divider: result appears DIV_LAT enabled clocks after its operands.
  logic [21:0] pipe [DIV_LAT];
  initial for (int i = 0; i < DIV_LAT; i++) pipe[i] = '0;
  always @(posedge clk_50M) begin
    if (div_clken) begin
      for (int i = DIV_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (div_denom != 0) ? div_numer / {10'd0, div_denom} : '0;
    end
  end
  assign div_quotient = pipe[DIV_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_level(input int t, input int v);
    int d, r;
    d = (t > OFFSET) ? t - OFFSET : 0;
    r = (GAIN * d) / v + OFFSET;
    return (r > 4095) ? 4095 : r;
  endfunction

  // Monitor: logs valid strobes and counts pulses/enables between clears.
  typedef struct { int cyc; int val; } ev_t;
  ev_t vq[$];
  int cyc = 0;
  int n_err, n_ovr, n_clken, n_busy;
  logic        clken_prev = 1'b0;
  logic [21:0] numer_prev = '0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (!rst) begin
      if (tlv_valid) vq.push_back('{cyc, int'(tlvnxt)});
      if (err_vpp) n_err++;
      if (overrun) n_ovr++;
      if (div_clken) n_clken++;
      if (busy) n_busy++;
      if (div_clken && clken_prev) check("numer_stable", int'(div_numer), int'(numer_prev));
    end
    clken_prev = div_clken;
    numer_prev = div_numer;
  end

  task automatic clear_mon();
    vq.delete();
    n_err = 0; n_ovr = 0; n_clken = 0; n_busy = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_50M);
    #1;
  endtask

  int cur_level;

  // One isolated request; exp_level < 0 means the level must not change.
  task automatic run_req(input int t, input int v, input int exp_numer, input int exp_level,
                         input bit exp_err, input string tag);
    int e, lvl;
    lvl = (exp_level < 0) ? cur_level : exp_level;
    @(negedge clk_50M); #1;
    tlv_i = 12'(t); vpp_i = 12'(v); found = 1'b1;
    @(posedge clk_50M);
    clear_mon();
    step(1);
    e = cyc;
    found = 1'b0;
    if (!exp_err) begin
      check({tag, " numer"}, int'(div_numer), exp_numer);
      check({tag, " denom"}, int'(div_denom), v);
    end
    step(DIV_LAT + 6);
    check({tag, " err_cnt"}, n_err, exp_err ? 1 : 0);
    check({tag, " clken_cycles"}, n_clken, exp_err ? 0 : DIV_LAT + 1);
    check({tag, " busy_cycles"}, n_busy, exp_err ? 0 : DIV_LAT + 3);
    check({tag, " valid_cnt"}, vq.size(), exp_err ? 0 : 1);
    if (vq.size() > 0) check({tag, " valid_latency"}, vq[0].cyc - e, DIV_LAT + 2);
    check({tag, " tlvnxt"}, int'(tlvnxt), lvl);
    cur_level = lvl;
  endtask

  typedef struct {
    int tlv;
    int vpp;
    int exp_numer;
    int exp_level;
    bit exp_err;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int e, t, v;
    vecs[0] = '{2000, 1000,  934650, 2331, 1'b0};
    vecs[1] = '{1397,  500,       0, 1397, 1'b0};
    vecs[2] = '{1000,  800,       0, 1397, 1'b0};
    vecs[3] = '{4095,   16, 4181900, 4095, 1'b0};
    vecs[4] = '{2500,   10,       0,   -1, 1'b1};
    vecs[5] = '{1398, 4095,    1550, 1397, 1'b0};
    vecs[6] = '{2500,   15,       0,   -1, 1'b1};
    vecs[7] = '{4095, 4095, 4181900, 2418, 1'b0};
    vecs[8] = '{3000, 1000, 2484650, 3881, 1'b0};

    rst = 1'b1; found = 1'b0; vpp_i = '0; tlv_i = '0;
    clear_mon();
    #1;
    check("rst tlvnxt", int'(tlvnxt), TLV_INIT);
    check("rst tlv_valid", int'(tlv_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst err_vpp", int'(err_vpp), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst div_clken", int'(div_clken), 0);
    check("rst div_numer", int'(div_numer), 0);
    check("rst div_denom", int'(div_denom), 0);
    cur_level = TLV_INIT;
    step(3);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 9; i++)
      run_req(vecs[i].tlv, vecs[i].vpp, vecs[i].exp_numer, vecs[i].exp_level,
              vecs[i].exp_err, $sformatf("vec%0d", i));

    // Pending then overwritten pending during RUN.
    @(negedge clk_50M); #1;
    tlv_i = 12'd2000; vpp_i = 12'd1000; found = 1'b1;
    @(posedge clk_50M);
    clear_mon();
    step(1);
    e = cyc;
    found = 1'b0;
    step(3);
    tlv_i = 12'd3000; vpp_i = 12'd2000; found = 1'b1;
    step(1);
    found = 1'b0;
    step(1);
    tlv_i = 12'd3000; vpp_i = 12'd1000; found = 1'b1;
    step(1);
    found = 1'b0;
    step(24);
    check("pend overrun_cnt", n_ovr, 1);
    check("pend err_cnt", n_err, 0);
    check("pend valid_cnt", vq.size(), 2);
    check("pend clken_cycles", n_clken, 2 * (DIV_LAT + 1));
    if (vq.size() > 0) begin
      check("pend first_latency", vq[0].cyc - e, DIV_LAT + 2);
      check("pend first_level", vq[0].val, ref_level(2000, 1000));
    end
    if (vq.size() > 1) begin
      check("pend second_latency", vq[1].cyc - e, 2 * (DIV_LAT + 2) + 1);
      check("pend second_level", vq[1].val, ref_level(3000, 1000));
    end
    check("pend busy_end", int'(busy), 0);
    cur_level = ref_level(3000, 1000);

    // found held high for 50 cycles triggers once.
    @(negedge clk_50M); #1;
    tlv_i = 12'd2000; vpp_i = 12'd1000; found = 1'b1;
    @(posedge clk_50M);
    clear_mon();
    step(50);
    found = 1'b0;
    step(15);
    check("held valid_cnt", vq.size(), 1);
    check("held clken_cycles", n_clken, DIV_LAT + 1);
    check("held tlvnxt", int'(tlvnxt), 2331);
    cur_level = 2331;

    // Reset mid-RUN with a request pending.
    @(negedge clk_50M); #1;
    tlv_i = 12'd3000; vpp_i = 12'd1000; found = 1'b1;
    @(posedge clk_50M);
    clear_mon();
    step(1);
    found = 1'b0;
    step(1);
    tlv_i = 12'd2000; found = 1'b1;
    step(1);
    found = 1'b0;
    @(negedge clk_50M); #3;
    rst = 1'b1;
    #1;
    check("midrst tlvnxt", int'(tlvnxt), TLV_INIT);
    check("midrst busy", int'(busy), 0);
    check("midrst div_clken", int'(div_clken), 0);
    check("midrst div_numer", int'(div_numer), 0);
    check("midrst div_denom", int'(div_denom), 0);
    check("midrst tlv_valid", int'(tlv_valid), 0);
    step(2);
    rst = 1'b0;
    step(25);
    check("midrst valid_cnt", vq.size(), 0);
    check("midrst busy_after", int'(busy), 0);
    check("midrst tlvnxt_after", int'(tlvnxt), TLV_INIT);
    cur_level = TLV_INIT;
    run_req(2000, 1000, 934650, 2331, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(4095, 0));
      if ($urandom_range(7, 0) == 0) v = int'($urandom_range(31, 0));
      else v = int'($urandom_range(4095, VPP_MIN));
      if (v < VPP_MIN)
        run_req(t, v, 0, -1, 1'b1, $sformatf("rnd%0d", i));
      else
        run_req(t, v, GAIN * ((t > OFFSET) ? t - OFFSET : 0), ref_level(t, v), 1'b0,
                $sformatf("rnd%0d", i));
      step(int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
